mem_sync_param: RTL and testbench

- Parametrised single-port synchronous memory; successor of the fixed 8x32 memory block.
- Generalised in:
  - data width and depth;
  - read latency (pipelined read data with a valid strobe).
- Adds:
  - post-reset clear sweep with a ready flag;
  - sticky error detection for illegal requests.
- Sits behind the testbench/driver or a bus-side controller; read/write strobes are mutually exclusive per cycle.

---
 rtl/mem_sync_param_if.sv | 37 +++
 rtl/mem_sync_param.sv | 155 +++++++++++++++
 tb/tb_mem_sync_param.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_sync_param_if.sv
// Request/response bundle for mem_sync_param; master drives requests, slave is the memory.
// MEM_PARITY_EN adds the parity-inject request bit and the parity_err response bit.
interface mem_sync_param_if #(
  parameter int DW = 8,
  parameter int AW = 5
);
  logic          read;
  logic          write;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          ready;
  logic          err;
`ifdef MEM_PARITY_EN
  logic          par_inject;
  logic          parity_err;

  modport master (
    output read, write, addr, data_in, par_inject,
    input  data_out, data_valid, ready, err, parity_err
  );
  modport slave (
    input  read, write, addr, data_in, par_inject,
    output data_out, data_valid, ready, err, parity_err
  );
`else
  modport master (
    output read, write, addr, data_in,
    input  data_out, data_valid, ready, err
  );
  modport slave (
    input  read, write, addr, data_in,
    output data_out, data_valid, ready, err
  );
`endif
endinterface

// File: rtl/mem_sync_param.sv
// Parametrised single-port synchronous memory with post-reset clear sweep, pipelined reads
// and sticky illegal-request flag. Optional even parity per word under macro MEM_PARITY_EN.
module mem_sync_param #(
  parameter int            DW        = 8,
  parameter int            DEPTH     = 32,
  parameter int            RD_LAT    = 1,
  parameter logic [DW-1:0] CLEAR_VAL = '0,
  parameter int            AW        = $clog2(DEPTH)
) (
  input logic             clk,
  input logic             rst,
  mem_sync_param_if.slave bus
);

`ifdef MEM_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif
  localparam int unsigned   DEPTH_U  = DEPTH;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] clr_ptr_reg, clr_ptr_next;
  logic          ready_reg, ready_next;
  logic          err_reg, err_next;

  logic          addr_ok;
  logic          clr_en;
  logic          wr_en;
  logic          rd_en;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [MW-1:0] mem_wd;
  logic [MW-1:0] wr_word;
  logic [MW-1:0] clr_word;

  logic [MW-1:0] mem [DEPTH];

  logic          pipe_valid_reg [RD_LAT];
  logic [MW-1:0] pipe_word_reg  [RD_LAT];

  // Widen before comparing so non-power-of-two depths reject the unused top addresses.
  assign addr_ok = 32'(bus.addr) < DEPTH_U;

`ifdef MEM_PARITY_EN
  assign wr_word  = {(^bus.data_in) ^ bus.par_inject, bus.data_in};
  assign clr_word = {^CLEAR_VAL, CLEAR_VAL};
`else
  assign wr_word  = bus.data_in;
  assign clr_word = CLEAR_VAL;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_ptr_reg <= '0;
      ready_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
      ready_reg   <= ready_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    ready_next   = ready_reg;
    err_next     = err_reg;
    clr_en       = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    case (state_reg)
      CLEAR: begin
        // Requests are silently dropped while sweeping; they never raise err.
        clr_en       = 1'b1;
        clr_ptr_next = clr_ptr_reg + AW'(1);
        if (clr_ptr_reg == LAST_PTR) begin
          state_next   = IDLE;
          ready_next   = 1'b1;
          clr_ptr_next = '0;
        end
      end
      IDLE: begin
        if (bus.read && bus.write) begin
          err_next = 1'b1;
        end else if ((bus.read || bus.write) && !addr_ok) begin
          err_next = 1'b1;
        end else begin
          wr_en = bus.write;
          rd_en = bus.read;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // One shared write port: the sweep and normal writes never overlap in time.
  assign mem_we = !rst && (clr_en || wr_en);
  assign mem_wa = clr_en ? clr_ptr_reg : bus.addr;
  assign mem_wd = clr_en ? clr_word : wr_word;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Stage 0 is the RAM output register; further stages only add latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid_reg[0] <= 1'b0;
      pipe_word_reg[0]  <= '0;
    end else begin
      pipe_valid_reg[0] <= rd_en;
      if (rd_en) begin
        pipe_word_reg[0] <= mem[bus.addr];
      end
    end
  end

  generate
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_valid_reg[gi] <= 1'b0;
          pipe_word_reg[gi]  <= '0;
        end else begin
          pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
          if (pipe_valid_reg[gi-1]) begin
            pipe_word_reg[gi] <= pipe_word_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  // Last stage only loads on a valid read, so data_out holds between strobes.
  assign bus.data_out   = pipe_word_reg[RD_LAT-1][DW-1:0];
  assign bus.data_valid = pipe_valid_reg[RD_LAT-1];
  assign bus.ready      = ready_reg;
  assign bus.err        = err_reg;
`ifdef MEM_PARITY_EN
  assign bus.parity_err = pipe_valid_reg[RD_LAT-1] && (^pipe_word_reg[RD_LAT-1]);
`endif

endmodule

// File: tb/tb_mem_sync_param.sv
// Directed bench: dut_a uses default parameters, dut_b is DEPTH=20 / RD_LAT=3 / CLEAR_VAL=8'h5A.
// Parity scenario is compiled only when MEM_PARITY_EN is defined.
module tb_mem_sync_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_sync_param_if #(.DW(8), .AW(5)) bus_a ();
  mem_sync_param_if #(.DW(8), .AW(5)) bus_b ();

  mem_sync_param #(.DW(8), .DEPTH(32), .RD_LAT(1), .CLEAR_VAL(8'h00)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  mem_sync_param #(.DW(8), .DEPTH(20), .RD_LAT(3), .CLEAR_VAL(8'h5A)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.read    = 1'b0;
    bus_a.write   = 1'b0;
    bus_a.addr    = '0;
    bus_a.data_in = '0;
`ifdef MEM_PARITY_EN
    bus_a.par_inject = 1'b0;
`endif
  endtask

  task automatic idle_b();
    bus_b.read    = 1'b0;
    bus_b.write   = 1'b0;
    bus_b.addr    = '0;
    bus_b.data_in = '0;
`ifdef MEM_PARITY_EN
    bus_b.par_inject = 1'b0;
`endif
  endtask

  task automatic test_reset();
    logic exp_rdy;
    rst_a = 1'b1;
    idle_a();
    tick();
    tick();
    n_cmp++; if (bus_a.ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", bus_a.ready); end
    n_cmp++; if (bus_a.data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus_a.data_valid); end
    n_cmp++; if (bus_a.data_out !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %h want 00", bus_a.data_out); end
    n_cmp++; if (bus_a.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus_a.err); end
    rst_a = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      // Illegal-looking requests during the sweep must be ignored.
      if (i <= 4) begin
        bus_a.read  = 1'b1;
        bus_a.write = 1'b1;
        bus_a.addr  = 5'd31;
      end else begin
        idle_a();
      end
      tick();
      exp_rdy = (i == 32);
      n_cmp++;
      if (bus_a.ready !== exp_rdy) begin
        n_bad++; $display("FAIL sweep_ready edge %0d: got %b want %b", i, bus_a.ready, exp_rdy);
      end
    end
    n_cmp++; if (bus_a.err !== 1'b0) begin n_bad++; $display("FAIL sweep_err: got %b want 0", bus_a.err); end
    n_cmp++; if (bus_a.data_valid !== 1'b0) begin n_bad++; $display("FAIL sweep_valid: got %b want 0", bus_a.data_valid); end
    $display("reset: ready after 32 edges, err=%b", bus_a.err);
  endtask

  task automatic test_clear_values();
    for (int i = 0; i < 32; i++) begin
      bus_a.read = 1'b1;
      bus_a.addr = 5'(i);
      tick();
      n_cmp++;
      if (bus_a.data_valid !== 1'b1 || bus_a.data_out !== 8'h00) begin
        n_bad++; $display("FAIL clear_read addr %0d: got v=%b d=%h want v=1 d=00", i, bus_a.data_valid, bus_a.data_out);
      end
      $display("clear read addr %0d -> %h", i, bus_a.data_out);
    end
    idle_a();
    tick();
    n_cmp++; if (bus_a.data_valid !== 1'b0) begin n_bad++; $display("FAIL clear_idle_valid: got %b want 0", bus_a.data_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    for (int i = 0; i < 4; i++) begin
      bus_a.write   = 1'b1;
      bus_a.addr    = 5'(i);
      bus_a.data_in = 8'h10 + 8'(i);
      tick();
      $display("b2b write addr %0d <- %h", i, bus_a.data_in);
    end
    bus_a.write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_a.read = 1'b1;
      bus_a.addr = 5'(i);
      tick();
      exp_d = 8'h10 + 8'(i);
      n_cmp++;
      if (bus_a.data_valid !== 1'b1 || bus_a.data_out !== exp_d) begin
        n_bad++; $display("FAIL b2b_read addr %0d: got v=%b d=%h want v=1 d=%h", i, bus_a.data_valid, bus_a.data_out, exp_d);
      end
      $display("b2b read addr %0d -> %h", i, bus_a.data_out);
    end
    idle_a();
    tick();
    n_cmp++;
    if (bus_a.data_valid !== 1'b0 || bus_a.data_out !== 8'h13) begin
      n_bad++; $display("FAIL b2b_hold: got v=%b d=%h want v=0 d=13", bus_a.data_valid, bus_a.data_out);
    end
  endtask

  task automatic test_write_then_read();
    logic [4:0] addrs [3] = '{5'd9, 5'd31, 5'd0};
    logic [7:0] datas [3] = '{8'h77, 8'hC3, 8'hFF};
    for (int k = 0; k < 3; k++) begin
      bus_a.write   = 1'b1;
      bus_a.addr    = addrs[k];
      bus_a.data_in = datas[k];
      tick();
      bus_a.write = 1'b0;
      bus_a.read  = 1'b1;
      tick();
      bus_a.read = 1'b0;
      n_cmp++;
      if (bus_a.data_valid !== 1'b1 || bus_a.data_out !== datas[k]) begin
        n_bad++; $display("FAIL wr_rd addr %0d: got v=%b d=%h want v=1 d=%h", addrs[k], bus_a.data_valid, bus_a.data_out, datas[k]);
      end
      $display("write-then-read addr %0d -> %h", addrs[k], bus_a.data_out);
    end
    idle_a();
    n_cmp++; if (bus_a.err !== 1'b0) begin n_bad++; $display("FAIL wr_rd_err: got %b want 0", bus_a.err); end
  endtask

`ifdef MEM_PARITY_EN
  task automatic test_parity();
    logic inj [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      bus_a.write      = 1'b1;
      bus_a.addr       = 5'd7;
      bus_a.data_in    = 8'h3C;
      bus_a.par_inject = inj[k];
      tick();
      bus_a.write      = 1'b0;
      bus_a.par_inject = 1'b0;
      bus_a.read       = 1'b1;
      tick();
      bus_a.read = 1'b0;
      n_cmp++;
      if (bus_a.data_valid !== 1'b1 || bus_a.data_out !== 8'h3C || bus_a.parity_err !== inj[k]) begin
        n_bad++; $display("FAIL parity inj=%b: got v=%b d=%h pe=%b want v=1 d=3c pe=%b",
                          inj[k], bus_a.data_valid, bus_a.data_out, bus_a.parity_err, inj[k]);
      end
      tick();
      n_cmp++; if (bus_a.parity_err !== 1'b0) begin n_bad++; $display("FAIL parity_pulse: got %b want 0", bus_a.parity_err); end
      $display("parity inject=%b -> parity_err pulse checked", inj[k]);
    end
    idle_a();
  endtask
`endif

  task automatic wait_sweep_b(input string tag);
    logic exp_rdy;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_rdy = (i == 20);
      n_cmp++;
      if (bus_b.ready !== exp_rdy || bus_b.data_valid !== 1'b0) begin
        n_bad++; $display("FAIL %s edge %0d: got rdy=%b v=%b want rdy=%b v=0", tag, i, bus_b.ready, bus_b.data_valid, exp_rdy);
      end
    end
  endtask

  task automatic test_latency();
    rst_b = 1'b1;
    idle_b();
    tick();
    tick();
    rst_b = 1'b0;
    wait_sweep_b("b_sweep");
    bus_b.write   = 1'b1;
    bus_b.addr    = 5'd5;
    bus_b.data_in = 8'hA5;
    tick();
    bus_b.write = 1'b0;
    bus_b.read  = 1'b1;
    tick();
    idle_b();
    n_cmp++; if (bus_b.data_valid !== 1'b0) begin n_bad++; $display("FAIL lat_e0: got v=%b want 0", bus_b.data_valid); end
    tick();
    n_cmp++; if (bus_b.data_valid !== 1'b0) begin n_bad++; $display("FAIL lat_e1: got v=%b want 0", bus_b.data_valid); end
    tick();
    n_cmp++;
    if (bus_b.data_valid !== 1'b1 || bus_b.data_out !== 8'hA5) begin
      n_bad++; $display("FAIL lat_e2: got v=%b d=%h want v=1 d=a5", bus_b.data_valid, bus_b.data_out);
    end
    tick();
    n_cmp++;
    if (bus_b.data_valid !== 1'b0 || bus_b.data_out !== 8'hA5) begin
      n_bad++; $display("FAIL lat_hold: got v=%b d=%h want v=0 d=a5", bus_b.data_valid, bus_b.data_out);
    end
    $display("latency: read addr 5 -> %h after 3 edges", bus_b.data_out);
  endtask

  // Reads every word of dut_b back-to-back and expects CLEAR_VAL three edges later.
  task automatic read_all_b(input string tag);
    for (int i = 0; i < 22; i++) begin
      if (i < 20) begin
        bus_b.read = 1'b1;
        bus_b.addr = 5'(i);
      end else begin
        idle_b();
      end
      tick();
      if (i >= 2) begin
        n_cmp++;
        if (bus_b.data_valid !== 1'b1 || bus_b.data_out !== 8'h5A) begin
          n_bad++; $display("FAIL %s addr %0d: got v=%b d=%h want v=1 d=5a", tag, i - 2, bus_b.data_valid, bus_b.data_out);
        end
      end
    end
    idle_b();
    tick();
    n_cmp++; if (bus_b.data_valid !== 1'b0) begin n_bad++; $display("FAIL %s tail: got v=%b want 0", tag, bus_b.data_valid); end
    $display("%s: 20 words read back", tag);
  endtask

  task automatic test_illegal();
    bus_b.read    = 1'b1;
    bus_b.write   = 1'b1;
    bus_b.addr    = 5'd3;
    bus_b.data_in = 8'hEE;
    tick();
    idle_b();
    n_cmp++; if (bus_b.err !== 1'b1) begin n_bad++; $display("FAIL rw_err: got %b want 1", bus_b.err); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus_b.data_valid !== 1'b0) begin n_bad++; $display("FAIL rw_novalid %0d: got %b want 0", i, bus_b.data_valid); end
    end
    bus_b.read = 1'b1;
    bus_b.addr = 5'd3;
    tick();
    idle_b();
    tick();
    tick();
    n_cmp++;
    if (bus_b.data_valid !== 1'b1 || bus_b.data_out !== 8'h5A || bus_b.err !== 1'b1) begin
      n_bad++; $display("FAIL rw_mem: got v=%b d=%h err=%b want v=1 d=5a err=1", bus_b.data_valid, bus_b.data_out, bus_b.err);
    end
    $display("illegal rd+wr addr 3: err=%b word=%h", bus_b.err, bus_b.data_out);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    n_cmp++; if (bus_b.err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", bus_b.err); end
    wait_sweep_b("b_resweep");
    bus_b.write   = 1'b1;
    bus_b.addr    = 5'd25;
    bus_b.data_in = 8'hEE;
    tick();
    bus_b.write = 1'b0;
    bus_b.read  = 1'b1;
    tick();
    idle_b();
    n_cmp++; if (bus_b.err !== 1'b1) begin n_bad++; $display("FAIL oob_err: got %b want 1", bus_b.err); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus_b.data_valid !== 1'b0) begin n_bad++; $display("FAIL oob_novalid %0d: got %b want 0", i, bus_b.data_valid); end
    end
    $display("out-of-range write/read addr 25: err=%b", bus_b.err);
    read_all_b("oob_scan");
  endtask

  task automatic test_reset_flush();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    wait_sweep_b("flush_sweep0");
    bus_b.write   = 1'b1;
    bus_b.addr    = 5'd2;
    bus_b.data_in = 8'h99;
    tick();
    bus_b.write = 1'b0;
    bus_b.read  = 1'b1;
    tick();
    idle_b();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    n_cmp++; if (bus_b.data_valid !== 1'b0) begin n_bad++; $display("FAIL flush_e1: got v=%b want 0", bus_b.data_valid); end
    for (int j = 1; j <= 10; j++) begin
      tick();
      n_cmp++;
      if (bus_b.data_valid !== 1'b0 || bus_b.ready !== 1'b0) begin
        n_bad++; $display("FAIL flush_sweep edge %0d: got v=%b rdy=%b want 0/0", j, bus_b.data_valid, bus_b.ready);
      end
    end
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    n_cmp++;
    if (bus_b.data_valid !== 1'b0 || bus_b.ready !== 1'b0) begin
      n_bad++; $display("FAIL flush_rst2: got v=%b rdy=%b want 0/0", bus_b.data_valid, bus_b.ready);
    end
    wait_sweep_b("flush_sweep");
    $display("reset mid-read and mid-sweep: ready=%b", bus_b.ready);
    read_all_b("flush_scan");
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    idle_a();
    idle_b();
    test_reset();
    test_clear_values();
    test_back_to_back();
    test_write_then_read();
`ifdef MEM_PARITY_EN
    test_parity();
`endif
    test_latency();
    test_illegal();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
